// File: rtl/fetch_buf_pkg.sv
// Shared sizing, entry type and PC helper for the fetch instruction buffer.
// FETCH_WIDTH, SIZE_PC and SIZE_INSTRUCTION may be overridden by defining the macros before this file.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif

package fetch_buf_pkg;
    localparam int FW          = `FETCH_WIDTH;
    localparam int DW          = `FETCH_WIDTH;
    localparam int DEPTH       = 16;
    localparam int PC_W        = `SIZE_PC;
    localparam int INST_W      = `SIZE_INSTRUCTION;
    localparam int FB_PTR_BITS = $clog2(DEPTH);
    localparam int FB_CNT_BITS = $clog2(DEPTH + 1);
    localparam int LANE_BITS   = (FW > 1) ? $clog2(FW) : 1;
    localparam int LCNT_BITS   = $clog2(FW + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetchBufEntry;

    // Lane PC = base + 4*lane, wrapping at PC_W bits.
    function automatic logic [PC_W-1:0] lane_pc(input logic [PC_W-1:0]      base,
                                                input logic [LANE_BITS-1:0] lane);
        lane_pc = base + {{(PC_W-LANE_BITS-2){1'b0}}, lane, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_lane_compact.sv
// Combinational lane compactor: maps each output slot to the source lane holding the
// slot-th set bit of the valid mask, and reports how many lanes are valid.
module fetch_lane_compact
    import fetch_buf_pkg::*;
(
    input  logic [FW-1:0]                valid_i,
    output logic [FW-1:0][LANE_BITS-1:0] src_lane_o,
    output logic [FW-1:0]                slot_valid_o,
    output logic [LCNT_BITS-1:0]         count_o
);
    logic [LCNT_BITS-1:0] rank;

    always_comb begin
        src_lane_o   = '0;
        slot_valid_o = '0;
        rank         = '0;
        for (int i = 0; i < FW; i++) begin
            if (valid_i[i]) begin
                src_lane_o[rank[LANE_BITS-1:0]]   = LANE_BITS'(i);
                slot_valid_o[rank[LANE_BITS-1:0]] = 1'b1;
                rank = rank + LCNT_BITS'(1);
            end
        end
        count_o = rank;
    end
endmodule

// File: rtl/fetch_inst_buffer.sv
// Circular instruction queue between I-cache fetch and decode.
// Optional FETCH_BUF_BYPASS_EN: an accepted packet into an empty buffer drives the decode outputs the same cycle.
module fetch_inst_buffer
    import fetch_buf_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         fetchValid_i,
    input  logic [PC_W-1:0]              fetchPC_i,
    input  logic [FW-1:0][INST_W-1:0]    inst_i,
    input  logic [FW-1:0]                instValid_i,
    output logic                         stall_o,
    input  logic                         decodeReady_i,
    output logic [DW-1:0][INST_W-1:0]    inst_o,
    output logic [DW-1:0][PC_W-1:0]      pc_o,
    output logic [DW-1:0]                instValid_o,
    output logic [FB_CNT_BITS-1:0]       occupancy_o
);
    fetchBufEntry mem_q [DEPTH];

    logic [FB_PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [FB_CNT_BITS-1:0] occ_q, occ_d;

    logic [FW-1:0][LANE_BITS-1:0] src_lane;
    logic [FW-1:0]                slot_valid;
    logic [LCNT_BITS-1:0]         lane_cnt;
    fetchBufEntry [FW-1:0]        slot_entry;
    fetchBufEntry [DW-1:0]        head_entry;
    fetchBufEntry [DW-1:0]        out_entry;
    logic [DW-1:0]                head_valid;

    logic                   accept, deq_en;
    logic [FB_CNT_BITS-1:0] enq_n, deq_m, skip_n;

    fetch_lane_compact u_compact (
        .valid_i      (instValid_i),
        .src_lane_o   (src_lane),
        .slot_valid_o (slot_valid),
        .count_o      (lane_cnt)
    );

    for (genvar gi = 0; gi < FW; gi++) begin : g_slot
        assign slot_entry[gi].inst = inst_i[src_lane[gi]];
        assign slot_entry[gi].pc   = lane_pc(fetchPC_i, src_lane[gi]);
    end

    // Stall depends on registered occupancy only, never on this cycle's pop.
    assign stall_o = (int'(DEPTH) - int'(occ_q)) < FW;
    assign accept  = fetchValid_i & ~stall_o & ~flush_i;
    assign deq_en  = decodeReady_i & ~flush_i;
    assign enq_n   = accept ? FB_CNT_BITS'(lane_cnt) : '0;

    always_comb begin
        deq_m = '0;
        if (deq_en) begin
            deq_m = (occ_q < FB_CNT_BITS'(DW)) ? occ_q : FB_CNT_BITS'(DW);
        end
    end

    for (genvar gi = 0; gi < DW; gi++) begin : g_head
        assign head_entry[gi] = mem_q[head_q + FB_PTR_BITS'(gi)];
        assign head_valid[gi] = occ_q > FB_CNT_BITS'(gi);
    end

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;
    assign bypass = accept && (occ_q == '0);
    // Lanes consumed straight from the bypass are never written into storage.
    assign skip_n = (bypass && decodeReady_i)
                  ? FB_CNT_BITS'((lane_cnt < LCNT_BITS'(DW)) ? lane_cnt : LCNT_BITS'(DW))
                  : '0;
    for (genvar gi = 0; gi < DW; gi++) begin : g_out
        assign out_entry[gi]   = bypass ? slot_entry[gi] : head_entry[gi];
        assign instValid_o[gi] = bypass ? slot_valid[gi] : head_valid[gi];
    end
`else
    assign skip_n = '0;
    for (genvar gi = 0; gi < DW; gi++) begin : g_out
        assign out_entry[gi]   = head_entry[gi];
        assign instValid_o[gi] = head_valid[gi];
    end
`endif

    for (genvar gi = 0; gi < DW; gi++) begin : g_out_data
        assign inst_o[gi] = out_entry[gi].inst;
        assign pc_o[gi]   = out_entry[gi].pc;
    end

    assign occupancy_o = occ_q;

    always_comb begin
        head_d = head_q + FB_PTR_BITS'(deq_m);
        tail_d = tail_q + FB_PTR_BITS'(enq_n - skip_n);
        occ_d  = occ_q + enq_n - skip_n - deq_m;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int s = 0; s < FW; s++) begin
            if (accept && slot_valid[s] && (FB_CNT_BITS'(s) >= skip_n)) begin
                mem_q[tail_q + FB_PTR_BITS'(s) - FB_PTR_BITS'(skip_n)] <= slot_entry[s];
            end
        end
    end

    a_occ_bounds: assert property (@(posedge clk) disable iff (!reset || flush_i)
        (int'(occ_q) + int'(enq_n) - int'(skip_n) - int'(deq_m)) inside {[0:DEPTH]});
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: directed vector table, hand sequences for
// fill/stall and pointer wrap, then randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_fetch_inst_buffer;
    import fetch_buf_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset, flush_i, fetchValid_i, decodeReady_i;
    logic [PC_W-1:0]           fetchPC_i;
    logic [FW-1:0][INST_W-1:0] inst_i;
    logic [FW-1:0]             instValid_i;
    logic                      stall_o;
    logic [DW-1:0][INST_W-1:0] inst_o;
    logic [DW-1:0][PC_W-1:0]   pc_o;
    logic [DW-1:0]             instValid_o;
    logic [FB_CNT_BITS-1:0]    occupancy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_inst_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .fetchValid_i  (fetchValid_i),
        .fetchPC_i     (fetchPC_i),
        .inst_i        (inst_i),
        .instValid_i   (instValid_i),
        .stall_o       (stall_o),
        .decodeReady_i (decodeReady_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .instValid_o   (instValid_o),
        .occupancy_o   (occupancy_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic             rst_n;
        logic             fl;
        logic             fv;
        logic [31:0]      pc;
        logic [3:0]       vm;
        logic             rdy;
        int               exp_occ;
        logic             exp_stall;
        logic [3:0]       exp_valid;
        logic [3:0][31:0] exp_pc;
    } vec_t;

    vec_t vecs[16];
    ent_t model_q[$];
    ent_t pkt[$];
    ent_t view[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic fv,
                         input logic [31:0] pc, input logic [3:0] vm, input logic rdy);
        reset         = rst_n;
        flush_i       = fl;
        fetchValid_i  = fv;
        fetchPC_i     = pc;
        instValid_i   = vm;
        decodeReady_i = rdy;
        for (int i = 0; i < FW; i++) inst_i[i] = $urandom;
    endtask

    function automatic logic [3:0][31:0] seq4(input logic [31:0] base);
        logic [3:0][31:0] r;
        for (int i = 0; i < 4; i++) r[i] = base + 32'(4 * i);
        return r;
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic fl, input logic fv,
                                input logic [31:0] pc, input logic [3:0] vm, input logic rdy,
                                input int occ, input logic st, input logic [3:0] v,
                                input logic [3:0][31:0] epc);
        vec_t t;
        t.rst_n = rst_n; t.fl = fl; t.fv = fv; t.pc = pc; t.vm = vm; t.rdy = rdy;
        t.exp_occ = occ; t.exp_stall = st; t.exp_valid = v; t.exp_pc = epc;
        return t;
    endfunction

    initial begin
        logic [3:0][31:0] pc_holes;
        logic [3:0][31:0] none;
        none = '0;
        pc_holes = '0;
        pc_holes[0] = 32'h2000;
        pc_holes[1] = 32'h2008;

        // Expected outputs describe the cycle after each row's inputs are clocked in.
        vecs[0]  = mk(0, 0, 0, 32'h0,    4'b0000, 0,  0, 0, 4'b0000, none);
        vecs[1]  = mk(0, 0, 0, 32'h0,    4'b0000, 0,  0, 0, 4'b0000, none);
        vecs[2]  = mk(1, 0, 0, 32'h0,    4'b0000, 0,  0, 0, 4'b0000, none);
        vecs[3]  = mk(1, 0, 1, 32'h1000, 4'b1111, 0,  4, 0, 4'b1111, seq4(32'h1000));
        vecs[4]  = mk(1, 1, 0, 32'h0,    4'b0000, 0,  0, 0, 4'b0000, none);
        vecs[5]  = mk(1, 0, 1, 32'h2000, 4'b0101, 0,  2, 0, 4'b0011, pc_holes);
        vecs[6]  = mk(1, 1, 0, 32'h0,    4'b0000, 0,  0, 0, 4'b0000, none);
        vecs[7]  = mk(1, 0, 1, 32'h3000, 4'b1111, 0,  4, 0, 4'b1111, seq4(32'h3000));
        vecs[8]  = mk(1, 0, 1, 32'h3010, 4'b1111, 0,  8, 0, 4'b1111, seq4(32'h3000));
        vecs[9]  = mk(1, 0, 1, 32'h3020, 4'b1111, 0, 12, 0, 4'b1111, seq4(32'h3000));
        vecs[10] = mk(1, 0, 1, 32'h3030, 4'b1111, 0, 16, 1, 4'b1111, seq4(32'h3000));
        vecs[11] = mk(1, 0, 1, 32'h4000, 4'b1111, 0, 16, 1, 4'b1111, seq4(32'h3000));
        vecs[12] = mk(1, 0, 0, 32'h0,    4'b0000, 1, 12, 0, 4'b1111, seq4(32'h3010));
        vecs[13] = mk(1, 0, 1, 32'h5000, 4'b0001, 1,  9, 0, 4'b1111, seq4(32'h3020));
        vecs[14] = mk(1, 1, 1, 32'h6000, 4'b1111, 1,  0, 0, 4'b0000, none);
        vecs[15] = mk(1, 0, 1, 32'h6100, 4'b0000, 0,  0, 0, 4'b0000, none);

        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].rst_n, vecs[r].fl, vecs[r].fv, vecs[r].pc, vecs[r].vm, vecs[r].rdy);
            @(negedge clk);
            #1;
            check($sformatf("row%0d occupancy", r), 64'(occupancy_o), 64'(vecs[r].exp_occ));
            check($sformatf("row%0d stall", r), 64'(stall_o), 64'(vecs[r].exp_stall));
            check($sformatf("row%0d instValid", r), 64'(instValid_o), 64'(vecs[r].exp_valid));
            for (int i = 0; i < 4; i++) begin
                if (vecs[r].exp_valid[i])
                    check($sformatf("row%0d pc%0d", r, i), 64'(pc_o[i]), 64'(vecs[r].exp_pc[i]));
            end
            $display("row %0d: occ=%0d stall=%0b valid=%b pc0=%h", r, occupancy_o, stall_o,
                     instValid_o, pc_o[0]);
        end

        // Steady 4-in/4-out long enough to wrap both pointers several times.
        drive(1, 0, 1, 32'h6000, 4'b1111, 0);
        @(negedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 1, 32'h6010 + 32'(16 * k), 4'b1111, 1);
            @(negedge clk);
            #1;
            check($sformatf("wrap%0d occupancy", k), 64'(occupancy_o), 64'd4);
            check($sformatf("wrap%0d instValid", k), 64'(instValid_o), 64'hF);
            for (int i = 0; i < 4; i++)
                check($sformatf("wrap%0d pc%0d", k, i), 64'(pc_o[i]),
                      64'(32'h6000 + 32'(16 * (k + 1)) + 32'(4 * i)));
            $display("wrap %0d: occ=%0d pc0=%h", k, occupancy_o, pc_o[0]);
        end

`ifdef FETCH_BUF_BYPASS_EN
        drive(1, 1, 0, 32'h0, 4'b0000, 0);
        @(negedge clk);
        #1;
        drive(1, 0, 1, 32'h7000, 4'b1111, 1);
        #1;
        check("bypass instValid", 64'(instValid_o), 64'hF);
        check("bypass pc0", 64'(pc_o[0]), 64'h7000);
        check("bypass pc3", 64'(pc_o[3]), 64'h700C);
        @(negedge clk);
        #1;
        check("bypass occupancy", 64'(occupancy_o), 64'd0);
        $display("bypass: occ=%0d", occupancy_o);
`endif

        // Randomized traffic against a queue model.
        drive(0, 0, 0, 32'h0, 4'b0000, 0);
        @(negedge clk);
        model_q.delete();
        for (int c = 0; c < 500; c++) begin
            logic        rst_n, fl, fv, rdy, stall_e, accepted;
            logic [31:0] pc;
            logic [3:0]  vm, tv;
            int          k, m;
            rst_n = ($urandom_range(0, 59) != 0);
            fl    = ($urandom_range(0, 19) == 0);
            fv    = ($urandom_range(0, 3) != 0);
            vm    = 4'($urandom);
            rdy   = 1'($urandom_range(0, 1));
            pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            drive(rst_n, fl, fv, pc, vm, rdy);
            #1;

            stall_e  = (DEPTH - model_q.size()) < 4;
            accepted = fv && !stall_e && !fl;
            pkt.delete();
            for (int i = 0; i < 4; i++) begin
                if (vm[i]) begin
                    ent_t e;
                    e.inst = inst_i[i];
                    e.pc   = pc + 32'(4 * i);
                    pkt.push_back(e);
                end
            end
            view = model_q;
`ifdef FETCH_BUF_BYPASS_EN
            if (model_q.size() == 0 && accepted) view = pkt;
`endif
            k  = (view.size() < 4) ? view.size() : 4;
            tv = 4'((1 << k) - 1);
            check($sformatf("rnd%0d stall", c), 64'(stall_o), 64'(stall_e));
            check($sformatf("rnd%0d occupancy", c), 64'(occupancy_o), 64'(model_q.size()));
            check($sformatf("rnd%0d instValid", c), 64'(instValid_o), 64'(tv));
            for (int i = 0; i < k; i++) begin
                check($sformatf("rnd%0d pc%0d", c, i), 64'(pc_o[i]), 64'(view[i].pc));
                check($sformatf("rnd%0d inst%0d", c, i), 64'(inst_o[i]), 64'(view[i].inst));
            end
            $display("rnd %0d: rst_n=%0b fl=%0b fv=%0b vm=%b rdy=%0b occ=%0d", c, rst_n, fl, fv,
                     vm, rdy, occupancy_o);

            if (!rst_n || fl) begin
                model_q.delete();
            end else begin
                m = rdy ? ((model_q.size() < 4) ? model_q.size() : 4) : 0;
`ifdef FETCH_BUF_BYPASS_EN
                if (model_q.size() == 0 && accepted && rdy) begin
                    for (int i = 0; i < 4 && pkt.size() > 0; i++) void'(pkt.pop_front());
                end
`endif
                for (int i = 0; i < m; i++) void'(model_q.pop_front());
                if (accepted) begin
                    foreach (pkt[i]) model_q.push_back(pkt[i]);
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
